float_tally: RTL and testbench

FLOAT_TALLY -- requirements
Module: float_tally

---
 rtl/float_tally_pkg.sv | 30 +++
 rtl/float_classify.sv | 41 ++++
 rtl/float_tally.sv | 168 ++++++++++++++++
 tb/tb_float_tally.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/float_tally_pkg.sv
`default_nettype none
// ============================================================================
// Module   : float_tally_pkg
// Purpose  : Shared definitions for the float_tally block. Holds the one-hot
//            class bit indices, the FSM state encoding and the default
//            counter width.
// Revision : 1.0 - initial release
// ============================================================================
package float_tally_pkg;

    // Default width of every class counter and of frame_len
    localparam int CNT_W_DEFAULT = 16;

    // Bit positions inside the 5-bit one-hot class vector
    localparam int CLS_ZERO    = 0;
    localparam int CLS_NORM    = 1;
    localparam int CLS_SUB     = 2;
    localparam int CLS_INF     = 3;
    localparam int CLS_NAN     = 4;
    localparam int NUM_CLASSES = 5;

    // Frame sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : float_tally_pkg
`default_nettype wire

// File: rtl/float_classify.sv
`default_nettype none
// ============================================================================
// Module   : float_classify
// Purpose  : Purely combinational IEEE-754 single-precision classifier.
//            Produces a one-hot class vector (zero, normal, subnormal,
//            infinity, NaN); exactly one bit is set for any input.
// Ports    : i_num   - 32-bit single-precision operand
//            o_class - 5-bit one-hot class, bit indices from float_tally_pkg
// Revision : 1.0 - initial release
// ============================================================================
module float_classify
    import float_tally_pkg::*;
(
    input  logic [31:0]            i_num,
    output logic [NUM_CLASSES-1:0] o_class
);

    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_exp_min;
    logic        w_exp_max;
    logic        w_frac_nz;

    assign w_exp     = i_num[30:23];
    assign w_frac    = i_num[22:0];
    assign w_exp_min = (w_exp == 8'h00);
    assign w_exp_max = (w_exp == 8'hFF);
    assign w_frac_nz = |w_frac;

    // Sign bit is irrelevant to the class, so +0 and -0 both land in ZERO
    always_comb begin
        o_class           = '0;
        o_class[CLS_ZERO] = w_exp_min & ~w_frac_nz;
        o_class[CLS_SUB]  = w_exp_min &  w_frac_nz;
        o_class[CLS_INF]  = w_exp_max & ~w_frac_nz;
        o_class[CLS_NAN]  = w_exp_max &  w_frac_nz;
        o_class[CLS_NORM] = ~w_exp_min & ~w_exp_max;
    end

endmodule : float_classify
`default_nettype wire

// File: rtl/float_tally.sv
`default_nettype none
// ============================================================================
// Module   : float_tally
// Purpose  : Counts the IEEE-754 single-precision classes of a frame of
//            frame_len operands. A start pulse in IDLE opens a frame, each
//            in_valid & in_ready transfer bumps one class counter, and after
//            the last operand the block sits in DONE with stable counts
//            until ack returns it to IDLE (counts held until next start).
// Config   : FLOAT_TALLY_NAN_CAPTURE_EN - when defined, the first NaN of a
//            frame is latched into first_nan and nan_seen is raised; when
//            undefined both outputs are tied to zero.
// Ports    : clk, reset (async, active high)
//            start, frame_len          - frame open pulse and length
//            in_valid, num, in_ready   - operand stream handshake
//            done, ack                 - result ready / consumed
//            cnt_zero .. cnt_nan       - per-class tallies
//            first_nan, nan_seen       - first NaN operand and its flag
// Revision : 1.0 - initial release
// ============================================================================
module float_tally
    import float_tally_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             in_valid,
    input  logic [31:0]      num,
    output logic             in_ready,
    output logic             done,
    input  logic             ack,
    output logic [CNT_W-1:0] cnt_zero,
    output logic [CNT_W-1:0] cnt_norm,
    output logic [CNT_W-1:0] cnt_sub,
    output logic [CNT_W-1:0] cnt_inf,
    output logic [CNT_W-1:0] cnt_nan,
    output logic [31:0]      first_nan,
    output logic             nan_seen
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_remaining;
    logic [CNT_W-1:0]       r_cnt [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] w_class;
    logic                   w_open;
    logic                   w_xfer;

    float_classify u_classify (
        .i_num   (num),
        .o_class (w_class)
    );

    // start is only honoured in IDLE; ack only in DONE (handled in the FSM)
    assign w_open = (r_state == ST_IDLE) && start;
    assign w_xfer = in_valid && in_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // An empty frame has nothing to stream: finish at once
                    w_state_nxt = (frame_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (in_valid && (r_remaining == CNT_W'(1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                // ack wins over a simultaneous start because start is
                // decoded only in IDLE
                if (ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Remaining-operand counter and class tallies
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remaining <= '0;
        end else if (w_open) begin
            r_remaining <= frame_len;
        end else if (w_xfer) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // No overflow guard needed: a counter can never exceed frame_len
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_open) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_xfer) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (w_class[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign cnt_zero = r_cnt[CLS_ZERO];
    assign cnt_norm = r_cnt[CLS_NORM];
    assign cnt_sub  = r_cnt[CLS_SUB];
    assign cnt_inf  = r_cnt[CLS_INF];
    assign cnt_nan  = r_cnt[CLS_NAN];

    // ------------------------------------------------------------------
    // Optional first-NaN capture
    // ------------------------------------------------------------------
`ifdef FLOAT_TALLY_NAN_CAPTURE_EN
    logic [31:0] r_first_nan;
    logic        r_nan_seen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_nan <= '0;
            r_nan_seen  <= 1'b0;
        end else if (w_open) begin
            r_first_nan <= '0;
            r_nan_seen  <= 1'b0;
        end else if (w_xfer && w_class[CLS_NAN] && !r_nan_seen) begin
            r_first_nan <= num;
            r_nan_seen  <= 1'b1;
        end
    end

    assign first_nan = r_first_nan;
    assign nan_seen  = r_nan_seen;
`else
    assign first_nan = '0;
    assign nan_seen  = 1'b0;
`endif

endmodule : float_tally
`default_nettype wire

// File: tb/tb_float_tally.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_tally
// Purpose  : Directed self-checking bench for float_tally. Expected values
//            are hand-computed; first-NaN expectations follow the
//            FLOAT_TALLY_NAN_CAPTURE_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_tally;

    localparam int CNT_W = 16;

`ifdef FLOAT_TALLY_NAN_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] frame_len;
    logic             in_valid;
    logic [31:0]      num;
    logic             in_ready;
    logic             done;
    logic             ack;
    logic [CNT_W-1:0] cnt_zero;
    logic [CNT_W-1:0] cnt_norm;
    logic [CNT_W-1:0] cnt_sub;
    logic [CNT_W-1:0] cnt_inf;
    logic [CNT_W-1:0] cnt_nan;
    logic [31:0]      first_nan;
    logic             nan_seen;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] v8 [8];
    logic [31:0] vt [5];
    logic [31:0] exp_first;
    logic        exp_seen;

    float_tally #(.CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .num       (num),
        .in_ready  (in_ready),
        .done      (done),
        .ack       (ack),
        .cnt_zero  (cnt_zero),
        .cnt_norm  (cnt_norm),
        .cnt_sub   (cnt_sub),
        .cnt_inf   (cnt_inf),
        .cnt_nan   (cnt_nan),
        .first_nan (first_nan),
        .nan_seen  (nan_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_counts(input string tag, input int z, input int n,
                                input int s, input int i, input int q);
        check({tag, ".zero"}, 32'(cnt_zero), 32'(z));
        check({tag, ".norm"}, 32'(cnt_norm), 32'(n));
        check({tag, ".sub"},  32'(cnt_sub),  32'(s));
        check({tag, ".inf"},  32'(cnt_inf),  32'(i));
        check({tag, ".nan"},  32'(cnt_nan),  32'(q));
    endtask

    initial begin
        v8[0] = 32'h00000000; v8[1] = 32'h80000000; v8[2] = 32'h28055554;
        v8[3] = 32'hA8055554; v8[4] = 32'h002AAAA8; v8[5] = 32'h7F800000;
        v8[6] = 32'h7F82AAA8; v8[7] = 32'hFFC00000;
        vt[0] = 32'h3F800000; vt[1] = 32'h7F800000; vt[2] = 32'h00000001;
        vt[3] = 32'h7FC00000; vt[4] = 32'h80000000;

        reset = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0;
        num = '0; ack = 1'b0;
        repeat (3) tick();

        // ---- reset state ----
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_counts("rst", 0, 0, 0, 0, 0);
        check("rst.first_nan", first_nan, 32'h0);
        check("rst.nan_seen", 32'(nan_seen), 32'd0);
        reset = 1'b0;
        tick();
        check("idle.in_ready", 32'(in_ready), 32'd0);

        // ---- 7-operand frame, in_valid every cycle ----
        start = 1'b1; frame_len = 16'd7;
        tick();
        start = 1'b0; frame_len = '0;
        check("f7.run_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 7; i++) begin
            num = v8[i]; in_valid = 1'b1;
            tick();
            if (i == 0) begin
                check("f7.latency_zero", 32'(cnt_zero), 32'd1);
                check("f7.not_done", 32'(done), 32'd0);
            end
        end
        in_valid = 1'b0;
        check("f7.done", 32'(done), 32'd1);
        check("f7.ready_low", 32'(in_ready), 32'd0);
        check_counts("f7", 2, 2, 1, 1, 1);
        exp_first = CAP ? 32'h7F82AAA8 : 32'h0;
        exp_seen  = CAP;
        check("f7.first_nan", first_nan, exp_first);
        check("f7.nan_seen", 32'(nan_seen), 32'(exp_seen));

        // ---- hold DONE without ack; a start pulse must be ignored ----
        for (int i = 0; i < 10; i++) begin
            start = (i == 3); frame_len = 16'd5;
            tick();
            check("hold.done", 32'(done), 32'd1);
            check("hold.norm", 32'(cnt_norm), 32'd2);
        end
        start = 1'b0;
        check_counts("hold", 2, 2, 1, 1, 1);

        // ---- ack together with start: only ack acts ----
        ack = 1'b1; start = 1'b1; frame_len = 16'd4;
        tick();
        ack = 1'b0; start = 1'b0;
        check("ackstart.done", 32'(done), 32'd0);
        check("ackstart.ready", 32'(in_ready), 32'd0);
        check_counts("ackstart", 2, 2, 1, 1, 1);
        tick();
        check("ackstart.idle", 32'(in_ready), 32'd0);

        // ---- 8-operand frame with trailing quiet NaN ----
        start = 1'b1; frame_len = 16'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            num = v8[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("f8.done", 32'(done), 32'd1);
        check_counts("f8", 2, 2, 1, 1, 2);
        check("f8.first_nan", first_nan, exp_first);
        check("f8.nan_seen", 32'(nan_seen), 32'(exp_seen));
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // ---- empty frame ----
        start = 1'b1; frame_len = '0;
        tick();
        start = 1'b0;
        check("f0.done", 32'(done), 32'd1);
        check("f0.ready", 32'(in_ready), 32'd0);
        check_counts("f0", 0, 0, 0, 0, 0);
        check("f0.nan_seen", 32'(nan_seen), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("f0.ack_idle", 32'(done), 32'd0);

        // ---- 3-operand frame with gapped in_valid and a stray start ----
        start = 1'b1; frame_len = 16'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); num = vt[i];
            start = (i == 1); frame_len = 16'd9;
            tick();
            if (i == 3) check("gap.not_done", 32'(done), 32'd0);
        end
        in_valid = 1'b0; start = 1'b0;
        check("gap.done", 32'(done), 32'd1);
        check_counts("gap", 1, 1, 1, 0, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // ---- reset mid-frame ----
        start = 1'b1; frame_len = 16'd5;
        tick();
        start = 1'b0;
        num = 32'h3F800000; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("mid.norm2", 32'(cnt_norm), 32'd2);
        #1 reset = 1'b1;
        #1;
        check("mid.async_norm", 32'(cnt_norm), 32'd0);
        check("mid.async_ready", 32'(in_ready), 32'd0);
        check("mid.async_done", 32'(done), 32'd0);
        #1 reset = 1'b0;
        tick();
        check("mid.wait_idle", 32'(in_ready), 32'd0);
        start = 1'b1; frame_len = 16'd1;
        tick();
        start = 1'b0;
        num = 32'h7F800000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post.done", 32'(done), 32'd1);
        check_counts("post", 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_float_tally
`default_nettype wire
